// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encoding, client indices and VGA vertical timing for the pong datapath.
package pong_pkg;
    typedef enum logic [1:0] {IDLE, SELECT, WAIT, DONE} state_t;
    localparam int N_CLIENTS_DEF = 4;
    localparam int PADDLE_L = 0;
    localparam int PADDLE_R = 1;
    localparam int BALL     = 2;
    localparam int SCORE    = 3;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
endpackage

// File: rtl/vsync_fall_detect.sv
// vsync_fall_detect: 2-FF synchronizer plus edge flop; tick pulses one cycle per vsync falling edge.
module vsync_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);
    logic s1, s2, d;
    // Preset to 1 so an idle-high vsync at reset release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            d  <= 1'b1;
        end else begin
            s1 <= vsync;
            s2 <= s1;
            d  <= s2;
        end
    end
    assign tick = d & ~s2;
endmodule

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: grants per-frame update slots to clients in index order during vblank,
// with per-client timeout and sticky overrun/timeout status.
module frame_update_scheduler
    import pong_pkg::*;
#(
    parameter int N_CLIENTS = N_CLIENTS_DEF,
    parameter int TIMEOUT   = 4096,
    parameter int TO_W      = 13,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vsync,
    input  logic                         pause,
    input  logic [N_CLIENTS-1:0]         client_en,
    input  logic [N_CLIENTS-1:0]         upd_done,
    input  logic                         clr_err,
    output logic [N_CLIENTS-1:0]         upd_req,
    output logic                         busy,
    output logic                         frame_done,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic                         overrun,
    output logic [7:0]                   overrun_cnt,
    output logic                         timeout_err,
    output logic [$clog2(N_CLIENTS)-1:0] err_client
);
    localparam int IW = $clog2(N_CLIENTS);
    localparam int PW = IW + 1;

    logic tick;
    vsync_fall_detect u_det (.clk(clk), .rst_n(rst_n), .vsync(vsync), .tick(tick));

    state_t               state, state_n;
    logic [N_CLIENTS-1:0] en_lat;
    logic [PW-1:0]        ptr;
    logic [IW-1:0]        cur, hit_idx;
    logic [TO_W-1:0]      to_cnt;
    logic                 hit, accept, granted_done, expire, ovr_set;

    // Lowest enabled index at or above ptr.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (en_lat[i] && PW'(i) >= ptr) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign accept       = state == IDLE && tick && !pause;
    assign granted_done = upd_done[cur];
    assign expire       = state == WAIT && !granted_done && to_cnt == TO_W'(1);
    assign ovr_set      = tick && state != IDLE;
    assign busy         = state != IDLE;
    assign frame_done   = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? SELECT : IDLE;
            SELECT:  state_n = hit ? WAIT : DONE;
            WAIT:    state_n = (granted_done || expire) ? SELECT : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_lat      <= '0;
            ptr         <= '0;
            cur         <= '0;
            to_cnt      <= '0;
            upd_req     <= '0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            err_client  <= '0;
        end else begin
            if (accept) begin
                en_lat <= client_en;
                ptr    <= '0;
            end
            if (state == SELECT && hit) begin
                upd_req <= N_CLIENTS'(1) << hit_idx;
                cur     <= hit_idx;
                to_cnt  <= TO_W'(TIMEOUT);
            end
            if (state == WAIT) begin
                if (granted_done || expire) begin
                    upd_req <= '0;
                    ptr     <= PW'(cur) + PW'(1);
                end else begin
                    to_cnt <= to_cnt - TO_W'(1);
                end
            end
            if (tick) frame_cnt <= frame_cnt + CNT_W'(1);
            // A set event in the same cycle as clr_err still lands on top of the clear.
            if (ovr_set) begin
                overrun     <= 1'b1;
                overrun_cnt <= clr_err ? 8'd1 : (overrun_cnt == 8'hFF ? 8'hFF : overrun_cnt + 8'd1);
            end else if (clr_err) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end
            if (expire) begin
                timeout_err <= 1'b1;
                err_client  <= cur;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
                err_client  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb_frame_update_scheduler: scoreboard bench; frame-level model predicts grant/done events and status.
module tb_frame_update_scheduler;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, pause = 1'b0, clr_err = 1'b0;
    logic [N-1:0]   client_en = '0, upd_done = '0, upd_req;
    logic           busy, frame_done, overrun, timeout_err;
    logic [15:0]    frame_cnt;
    logic [7:0]     overrun_cnt;
    logic [1:0]     err_client;

    frame_update_scheduler #(.N_CLIENTS(N), .TIMEOUT(TMO), .TO_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .client_en(client_en),
        .upd_done(upd_done), .clr_err(clr_err), .upd_req(upd_req), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .overrun(overrun),
        .overrun_cnt(overrun_cnt), .timeout_err(timeout_err), .err_client(err_client)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_done; int idx; int len;} ev_t;
    ev_t        exp_q[$];
    int         n_cmp = 0, n_err = 0;
    int         dly[N];
    bit         noise = 1'b0, mon_en = 1'b1;
    logic [15:0] m_fc = '0;
    bit         m_ovr = 1'b0, m_to = 1'b0;
    int         m_ocnt = 0, m_ec = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic emit(input bit d, input int idx, input int len, input int g);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got done=%0d idx=%0d len=%0d want none", d, idx, len);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", d, e.is_done);
            if (!d && !e.is_done) begin
                check("grant_idx", idx, e.idx);
                check("grant_len", len, e.len);
            end
            check("gap_cycles", g, 1);
        end
    endtask

    // Client responders: done pulses on the dly-th cycle of a grant (0 = never); noise when not granted.
    initial begin
        int cnt[N];
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (upd_req[i]) begin
                    cnt[i]++;
                    upd_done[i] = (cnt[i] == dly[i]);
                end else begin
                    cnt[i] = 0;
                    upd_done[i] = noise && ($urandom_range(3) == 0);
                end
            end
        end
    end

    // Monitor: turns DUT outputs into grant/done events and checks them against the queue.
    initial begin
        bit in_g = 1'b0;
        int len = 0, gap = 0, gidx = 0, ggap = 0;
        logic [N-1:0] held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                in_g = 1'b0;
                gap  = 0;
                continue;
            end
            if (in_g && upd_req != held) begin
                emit(1'b0, gidx, len, ggap);
                in_g = 1'b0;
                gap  = 0;
            end
            if (!in_g && upd_req != '0) begin
                held = upd_req;
                check("req_onehot", $onehot(upd_req), 1);
                gidx = $clog2(upd_req);
                in_g = 1'b1;
                len  = 0;
                ggap = gap;
            end
            if (in_g) len++;
            if (frame_done) begin
                emit(1'b1, 0, 1, gap);
                gap = 0;
            end
            if (busy && upd_req == '0 && !frame_done) gap++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_frame(input logic [N-1:0] en, input bit p);
        m_fc++;
        if (!p) begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    bit to = (dly[i] == 0 || dly[i] > TMO);
                    exp_q.push_back('{1'b0, i, to ? TMO : dly[i]});
                    if (to) begin
                        m_to = 1'b1;
                        m_ec = i;
                    end
                end
            end
            exp_q.push_back('{1'b1, 0, 1});
        end
    endtask

    // clr_err, when requested, is driven in exactly the cycle the resulting tick is high.
    task automatic vfall(input bit clr);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk);
        @(negedge clk) clr_err = clr;
        @(negedge clk);
        clr_err = 1'b0;
        vsync   = 1'b1;
        @(negedge clk);
    endtask

    task automatic vfall_ovr(input bit clr);
        m_fc++;
        m_ovr  = 1'b1;
        m_ocnt = clr ? 1 : (m_ocnt < 255 ? m_ocnt + 1 : 255);
        if (clr) begin
            m_to = 1'b0;
            m_ec = 0;
        end
        vfall(clr);
    endtask

    task automatic clr_only();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        m_ovr  = 1'b0;
        m_ocnt = 0;
        m_to   = 1'b0;
        m_ec   = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_req(input int i);
        int k = 0;
        while (!upd_req[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("wait_req", upd_req[i], 1);
    endtask

    task automatic check_status();
        check("frame_cnt", frame_cnt, m_fc);
        check("overrun", overrun, m_ovr);
        check("overrun_cnt", overrun_cnt, m_ocnt);
        check("timeout_err", timeout_err, m_to);
        check("err_client", err_client, m_ec);
    endtask

    task automatic run_frame(input logic [N-1:0] en, input bit p);
        client_en = en;
        pause     = p;
        model_frame(en, p);
        vfall(1'b0);
        client_en = N'($urandom);
        pause     = 1'($urandom_range(1));
        wait_idle();
        check_status();
    endtask

    initial begin
        int bad;
        logic [N-1:0] en;
        for (int i = 0; i < N; i++) dly[i] = 5;
        #1;
        check("reset_outputs", {upd_req, busy, frame_done, frame_cnt, overrun, overrun_cnt,
                                timeout_err, err_client}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame_cnt != 0 || upd_req != 0 || busy) bad++;
        end
        check("quiet_after_reset", bad, 0);

        run_frame(4'b1111, 1'b0);
        check("frame_cnt_first", frame_cnt, 1);
        run_frame(4'b0101, 1'b0);
        run_frame(4'b0000, 1'b0);

        dly[0] = 5; dly[1] = 0; dly[2] = 3;
        run_frame(4'b0110, 1'b0);
        check("timeout_client1", {timeout_err, err_client}, {1'b1, 2'd1});
        clr_only();
        dly[0] = 16;
        run_frame(4'b0001, 1'b0);
        check("done_on_expiry", timeout_err, 0);

        dly[0] = 10; dly[1] = 10;
        client_en = 4'b0011;
        pause     = 1'b0;
        model_frame(4'b0011, 1'b0);
        vfall(1'b0);
        wait_req(0);
        vfall_ovr(1'b0);
        check_status();
        wait_req(1);
        vfall_ovr(1'b1);
        wait_idle();
        check_status();
        check("overrun_cnt_setwins", overrun_cnt, 1);

        run_frame(4'b1111, 1'b1);

        dly[0] = 0;
        client_en = 4'b0001;
        pause     = 1'b0;
        vfall(1'b0);
        wait_req(0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_req", upd_req, 0);
        check("async_reset_busy", busy, 0);
        exp_q.delete();
        m_fc = '0; m_ovr = 1'b0; m_ocnt = 0; m_to = 1'b0; m_ec = 0;
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || upd_req != 0) bad++;
        end
        check("idle_after_reset", bad, 0);
        check_status();

        noise = 1'b1;
        repeat (40) begin
            en = N'($urandom);
            for (int i = 0; i < N; i++) dly[i] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(20, 1));
            if ($urandom_range(4) == 0) clr_only();
            run_frame(en, $urandom_range(5) == 0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
